instr_sequencer: RTL

- Fetch/decode/control stage directly upstream of the Accumulator and ProgramCounter.
- Reads the instruction at the current pc over a ready-handshaked memory port and decodes it.
- Drives the accumulator's data_in and load strobe, and the program counter's jump, jump_addr and advance strobe.
- Instruction format: [15:12] opcode, [11:0] operand.

---
 rtl/instr_sequencer_if.sv | 31 +++
 rtl/instr_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Ready-handshaked instruction/operand memory read port.
//               The sequencer drives the request side; memory answers with
//               mem_ready/mem_rdata.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
  parameter int DATA_W = 16
) ();
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Fetch/decode/control stage feeding the accumulator and the
//               program counter. Instruction = [15:12] opcode, [11:0] operand.
//               Optional macro INSTR_SEQ_ILLEGAL_TRAP_EN: illegal opcodes
//               halt the sequencer and raise the sticky illegal_op_o flag;
//               without it they execute as NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
  parameter int DATA_W     = 16,
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  instr_sequencer_if.master mem_bus,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] acc_i,
  output logic [DATA_W-1:0] data_in_o,
  output logic              acc_load_o,
  output logic              jump_o,
  output logic [DATA_W-1:0] jump_addr_o,
  output logic              pc_en_o,
  output logic              halted_o,
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
  output logic              bus_err_o,
  output logic              illegal_op_o
`else
  output logic              bus_err_o
`endif
);

  localparam int                c_WAIT_W   = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(WAIT_LIMIT);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);
  localparam logic [DATA_W-1:0]   c_PC_ONE   = DATA_W'(1);

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_OPERAND = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic                mem_req_q, mem_req_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   data_in_q, data_in_d;
  logic [DATA_W-1:0]   jump_addr_q, jump_addr_d;
  logic                acc_load_q, acc_load_d;
  logic                jump_q, jump_d;
  logic                pc_en_q, pc_en_d;
  logic                halted_q, halted_d;
  logic                bus_err_q, bus_err_d;
  logic                illegal_q, illegal_d;
  logic [c_WAIT_W-1:0] wait_q, wait_d;

  logic [3:0]          w_opcode;
  logic [DATA_W-1:0]   w_operand;
  logic [c_WAIT_W-1:0] w_wait_inc;
  logic                w_timeout;

  assign w_opcode   = ir_q[15:12];
  assign w_operand  = {{(DATA_W-12){1'b0}}, ir_q[11:0]};
  assign w_wait_inc = wait_q + c_WAIT_ONE;
  assign w_timeout  = (WAIT_LIMIT != 0) && (w_wait_inc == c_WAIT_MAX);

  // Next-state and next-output logic; strobes default low so each lasts one cycle.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    data_in_d   = data_in_q;
    jump_addr_d = jump_addr_q;
    acc_load_d  = 1'b0;
    jump_d      = 1'b0;
    pc_en_d     = 1'b0;
    halted_d    = halted_q;
    bus_err_d   = bus_err_q;
    illegal_d   = illegal_q;
    wait_d      = wait_q;

    case (state_q)
      ST_FETCH: begin
        if (!mem_req_q) begin
          // Only reached right after reset; later fetches are issued from COMMIT.
          mem_req_d  = 1'b1;
          mem_addr_d = pc_i;
          wait_d     = '0;
        end else if (mem_bus.mem_ready) begin
          ir_d      = mem_bus.mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_DECODE;
        end else if (w_timeout) begin
          bus_err_d = 1'b1;
          halted_d  = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_HALT;
        end else begin
          wait_d = w_wait_inc;
        end
      end

      ST_DECODE: begin
        case (w_opcode)
          4'h0: begin
            pc_en_d = 1'b1;
            state_d = ST_COMMIT;
          end
          4'h1: begin
            mem_req_d  = 1'b1;
            mem_addr_d = w_operand;
            wait_d     = '0;
            state_d    = ST_OPERAND;
          end
          4'h2: begin
            data_in_d  = w_operand;
            acc_load_d = 1'b1;
            pc_en_d    = 1'b1;
            state_d    = ST_COMMIT;
          end
          4'h3: begin
            jump_addr_d = w_operand;
            jump_d      = 1'b1;
            state_d     = ST_COMMIT;
          end
          4'h4: begin
            if (acc_i == '0) begin
              jump_addr_d = w_operand;
              jump_d      = 1'b1;
            end else begin
              pc_en_d = 1'b1;
            end
            state_d = ST_COMMIT;
          end
          4'hF: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
            halted_d  = 1'b1;
            state_d   = ST_HALT;
`else
            pc_en_d = 1'b1;
            state_d = ST_COMMIT;
`endif
          end
        endcase
      end

      ST_OPERAND: begin
        if (mem_bus.mem_ready) begin
          data_in_d  = mem_bus.mem_rdata;
          mem_req_d  = 1'b0;
          acc_load_d = 1'b1;
          pc_en_d    = 1'b1;
          state_d    = ST_COMMIT;
        end else if (w_timeout) begin
          bus_err_d = 1'b1;
          halted_d  = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_HALT;
        end else begin
          wait_d = w_wait_inc;
        end
      end

      ST_COMMIT: begin
        // The PC updates on this same edge, so the fetch address is the PC's
        // next value: the jump target, pc+1 after an advance, else pc.
        mem_req_d  = 1'b1;
        mem_addr_d = jump_q ? jump_addr_q : (pc_en_q ? pc_i + c_PC_ONE : pc_i);
        wait_d     = '0;
        state_d    = ST_FETCH;
      end

      ST_HALT: begin
        mem_req_d = 1'b0;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_FETCH;
      ir_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      data_in_q   <= '0;
      jump_addr_q <= '0;
      acc_load_q  <= 1'b0;
      jump_q      <= 1'b0;
      pc_en_q     <= 1'b0;
      halted_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      illegal_q   <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      data_in_q   <= data_in_d;
      jump_addr_q <= jump_addr_d;
      acc_load_q  <= acc_load_d;
      jump_q      <= jump_d;
      pc_en_q     <= pc_en_d;
      halted_q    <= halted_d;
      bus_err_q   <= bus_err_d;
      illegal_q   <= illegal_d;
      wait_q      <= wait_d;
    end
  end

  assign mem_bus.mem_req  = mem_req_q;
  assign mem_bus.mem_addr = mem_addr_q;
  assign data_in_o        = data_in_q;
  assign jump_addr_o      = jump_addr_q;
  assign acc_load_o       = acc_load_q;
  assign jump_o           = jump_q;
  assign pc_en_o          = pc_en_q;
  assign halted_o         = halted_q;
  assign bus_err_o        = bus_err_q;
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
  assign illegal_op_o     = illegal_q;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = illegal_q;
`endif

endmodule
`default_nettype wire
